// File: rtl/svc_mem_sram_lat.sv
// svc_mem_fifo: generic in-order FIFO holding DEPTH entries of W bits.
// Latency: an entry pushed at edge N is visible on head_dat/head_vld from edge N onward (next cycle).
// Backpressure: never stalls; the caller must not push while full, and pop is ignored while empty.
module svc_mem_fifo #(
   parameter int W     = 32,
   parameter int DEPTH = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         push,
   input  logic [W-1:0] push_dat,
   input  logic         pop,
   output logic [W-1:0] head_dat,
   output logic         head_vld
);
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   logic [W-1:0]  store [DEPTH];
   logic [PW-1:0] wptr;
   logic [PW-1:0] rptr;
   logic [CW-1:0] count;
   logic          do_pop;
   logic          full;

   function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign head_vld = (count != '0);
   assign head_dat = store[rptr];
   assign full     = (count == CW'(DEPTH));
   assign do_pop   = pop && head_vld;

   // Pointers and occupancy; reset discards every queued entry, including a coincident push.
   always_ff @(posedge clk) begin
      if (rst) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else begin
         if (push) wptr <= bump(wptr);
         if (do_pop) rptr <= bump(rptr);
         if (push && !do_pop) count <= count + 1'b1;
         else if (!push && do_pop) count <= count - 1'b1;
      end
   end

   // Entry storage; contents are meaningless until counted as valid.
   always_ff @(posedge clk) begin
      if (push) store[wptr] <= push_dat;
   end

   // Upstream credit accounting guarantees room; a push into a full FIFO is a design bug.
   assert property (@(posedge clk) disable iff (rst) !(push && full));
endmodule

// svc_mem_sram_lat: word-addressed, byte-strobed SRAM with a configurable read latency.
// Latency: read data valid RD_LATENCY cycles after accept (0 = combinational pass-through).
// Backpressure: rd_ready is a credit check on outstanding reads; writes are never stalled.
module svc_mem_sram_lat #(
   parameter int DW         = 32,
   parameter int AW         = 10,
   parameter int RD_LATENCY = 1,
   parameter int RSP_DEPTH  = 4,
   parameter     INIT_FILE  = ""
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [31:0]     rd_addr,
   input  logic            rd_valid,
   output logic            rd_ready,
   output logic [DW-1:0]   rd_data,
   output logic            rd_data_valid,
   input  logic            rd_data_ready,
   input  logic [31:0]     wr_addr,
   input  logic [DW-1:0]   wr_data,
   input  logic [DW/8-1:0] wr_strb,
   input  logic            wr_valid,
   output logic            wr_ready
);
   localparam int NB = DW / 8;
   localparam int SB = $clog2(NB);

   if (DW < 8 || (DW % 8) != 0) begin : g_bad_dw
      $fatal(1, "svc_mem_sram_lat: DW must be a multiple of 8 and at least 8");
   end
   if (RD_LATENCY < 0 || RD_LATENCY > 4) begin : g_bad_lat
      $fatal(1, "svc_mem_sram_lat: RD_LATENCY must be in 0..4");
   end
   if (RD_LATENCY > 0 && (RSP_DEPTH < RD_LATENCY || RSP_DEPTH < 1 ||
                          (RSP_DEPTH & (RSP_DEPTH - 1)) != 0)) begin : g_bad_depth
      $fatal(1, "svc_mem_sram_lat: RSP_DEPTH must be a power of 2 and >= RD_LATENCY");
   end

   logic [DW-1:0] mem [2**AW];
   logic [AW-1:0] rd_word;
   logic [AW-1:0] wr_word;
   logic [DW-1:0] rd_word_dat;
   logic          addr_unused;

   // Low byte-lane bits and bits above the array size are dropped, so addresses alias.
   assign rd_word     = rd_addr[AW+SB-1:SB];
   assign wr_word     = wr_addr[AW+SB-1:SB];
   assign rd_word_dat = mem[rd_word];
   assign wr_ready    = 1'b1;
   assign addr_unused = ^{rd_addr, wr_addr, rst};

   // Byte-strobed write port; not gated by reset so a write during reset still lands.
   always_ff @(posedge clk) begin
      for (int i = 0; i < NB; i++) begin
         if (wr_valid && wr_strb[i]) mem[wr_word][i*8 +: 8] <= wr_data[i*8 +: 8];
      end
   end

   if (RD_LATENCY == 0) begin : g_pass
      // Drop-in behaviour of the old zero-latency model.
      assign rd_data       = rd_word_dat;
      assign rd_data_valid = rd_valid;
      assign rd_ready      = rd_data_ready;
   end else begin : g_lat
      localparam int OW = $clog2(RSP_DEPTH + 1);

      logic          accept;
      logic          pop;
      logic          push;
      logic [DW-1:0] push_dat;
      logic [OW-1:0] outstanding;

      // Ready depends on state only, so there is no path from rd_valid or rd_data_ready.
      assign rd_ready = (outstanding < OW'(RSP_DEPTH));
      assign accept   = rd_valid && rd_ready;
      assign pop      = rd_data_valid && rd_data_ready;

      // Credit counter: reads accepted but not yet handed to the consumer.
      always_ff @(posedge clk) begin
         if (rst) outstanding <= '0;
         else if (accept && !pop) outstanding <= outstanding + 1'b1;
         else if (!accept && pop) outstanding <= outstanding - 1'b1;
      end

      if (RD_LATENCY == 1) begin : g_direct
         // The array is sampled straight into the response buffer at the accept edge.
         assign push     = accept;
         assign push_dat = rd_word_dat;
      end else begin : g_pipe
         localparam int NS = RD_LATENCY - 1;

         logic [NS-1:0] pipe_vld;
         logic [DW-1:0] pipe_dat [NS];

         // Valid shift chain; cleared on reset so in-flight reads vanish silently.
         always_ff @(posedge clk) begin
            if (rst) begin
               pipe_vld <= '0;
            end else begin
               pipe_vld[0] <= accept;
               for (int i = 1; i < NS; i++) pipe_vld[i] <= pipe_vld[i-1];
            end
         end

         // Data shift chain; stage 0 samples the array at the accept edge (old data on collision).
         always_ff @(posedge clk) begin
            pipe_dat[0] <= rd_word_dat;
            for (int i = 1; i < NS; i++) pipe_dat[i] <= pipe_dat[i-1];
         end

         assign push     = pipe_vld[NS-1];
         assign push_dat = pipe_dat[NS-1];
      end

      svc_mem_fifo #(
         .W     (DW),
         .DEPTH (RSP_DEPTH)
      ) u_rsp_fifo (
         .clk      (clk),
         .rst      (rst),
         .push     (push),
         .push_dat (push_dat),
         .pop      (pop),
         .head_dat (rd_data),
         .head_vld (rd_data_valid)
      );
   end
endmodule

// File: tb/tb_svc_mem_sram_lat.sv
// Bench for svc_mem_sram_lat: four instances (latency 2, 1, 0, 3) driven one at a time.
// Expected responses come from a byte-level memory image plus a queue of pending reads,
// each tagged with the earliest cycle it may appear; credits are the queue length.
module tb_svc_mem_sram_lat;
   localparam int NI    = 4;
   localparam int DEPTH = 4;

   typedef struct {
      logic [31:0] dat;
      int          due;
   } rsp_t;

   function automatic int lat_of(input int i);
      case (i)
         0:       return 2;
         1:       return 1;
         2:       return 0;
         default: return 3;
      endcase
   endfunction

   function automatic int aw_of(input int i);
      return (i == 2) ? 4 : 10;
   endfunction

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst           [NI];
   logic [31:0] rd_addr       [NI];
   logic        rd_valid      [NI];
   logic        rd_ready      [NI];
   logic [31:0] rd_data       [NI];
   logic        rd_data_valid [NI];
   logic        rd_data_ready [NI];
   logic [31:0] wr_addr       [NI];
   logic [31:0] wr_data       [NI];
   logic [3:0]  wr_strb       [NI];
   logic        wr_valid      [NI];
   logic        wr_ready      [NI];

   for (genvar g = 0; g < NI; g++) begin : g_dut
      svc_mem_sram_lat #(
         .DW         (32),
         .AW         (aw_of(g)),
         .RD_LATENCY (lat_of(g)),
         .RSP_DEPTH  (DEPTH)
      ) u_dut (
         .clk           (clk),
         .rst           (rst[g]),
         .rd_addr       (rd_addr[g]),
         .rd_valid      (rd_valid[g]),
         .rd_ready      (rd_ready[g]),
         .rd_data       (rd_data[g]),
         .rd_data_valid (rd_data_valid[g]),
         .rd_data_ready (rd_data_ready[g]),
         .wr_addr       (wr_addr[g]),
         .wr_data       (wr_data[g]),
         .wr_strb       (wr_strb[g]),
         .wr_valid      (wr_valid[g]),
         .wr_ready      (wr_ready[g])
      );
   end

   logic [31:0] mdl [NI][1024];
   rsp_t        q[$];
   int          cur;
   int          lat;
   int          cyc;
   int          n_chk;
   int          n_pass;

   function automatic int word_of(input logic [31:0] a);
      return int'((a >> 2) & ((32'd1 << aw_of(cur)) - 32'd1));
   endfunction

   function automatic logic exp_vld();
      if (lat == 0) return rd_valid[cur];
      return (q.size() > 0) && (q[0].due <= cyc);
   endfunction

   function automatic logic exp_rdy();
      if (lat == 0) return rd_data_ready[cur];
      return q.size() < DEPTH;
   endfunction

   task automatic idle(input int g);
      rd_addr[g]       = '0;
      rd_valid[g]      = 1'b0;
      rd_data_ready[g] = 1'b1;
      wr_addr[g]       = '0;
      wr_data[g]       = '0;
      wr_strb[g]       = '0;
      wr_valid[g]      = 1'b0;
   endtask

   task automatic select(input int g);
      cur = g;
      lat = lat_of(g);
      q.delete();
      idle(g);
      rst[g] = 1'b0;
   endtask

   // Apply this cycle's handshakes to the model, then move to just after the next rising edge.
   task automatic advance();
      logic        acc;
      logic        pop;
      logic [31:0] tmp;
      int          w;
      acc = rd_valid[cur] && exp_rdy();
      pop = exp_vld() && rd_data_ready[cur];
      if (rst[cur]) begin
         q.delete();
      end else if (lat > 0) begin
         if (pop) void'(q.pop_front());
         if (acc) q.push_back('{dat: mdl[cur][word_of(rd_addr[cur])], due: cyc + lat});
      end
      if (wr_valid[cur]) begin
         w   = word_of(wr_addr[cur]);
         tmp = mdl[cur][w];
         for (int b = 0; b < 4; b++) if (wr_strb[cur][b]) tmp[b*8 +: 8] = wr_data[cur][b*8 +: 8];
         mdl[cur][w] = tmp;
      end
      @(posedge clk);
      cyc++;
      #1;
   endtask

   task automatic init_mem(input int g);
      select(g);
      for (int w = 0; w < 16; w++) begin
         wr_valid[g] = 1'b1;
         wr_addr[g]  = w * 4;
         wr_data[g]  = $urandom;
         wr_strb[g]  = 4'hF;
         advance();
      end
      idle(g);
   endtask

   task automatic test_reset();
      for (int g = 0; g < NI; g++) begin
         idle(g);
         rst[g] = 1'b1;
      end
      repeat (2) @(posedge clk);
      #1;
      for (int g = 0; g < NI; g++) rst[g] = 1'b0;
      @(negedge clk);
      for (int g = 0; g < NI; g++) begin
         n_chk++;
         if (wr_ready[g] !== 1'b1) $display("FAIL reset_wr_ready inst=%0d got=%b exp=1", g, wr_ready[g]);
         else n_pass++;
         n_chk++;
         if (rd_data_valid[g] !== 1'b0) $display("FAIL reset_vld inst=%0d got=%b exp=0", g, rd_data_valid[g]);
         else n_pass++;
         n_chk++;
         if (rd_ready[g] !== 1'b1) $display("FAIL reset_rdy inst=%0d got=%b exp=1", g, rd_ready[g]);
         else n_pass++;
      end
   endtask

   task automatic test_write_read();
      select(0);
      wr_valid[0] = 1'b1;
      wr_addr[0]  = 32'h10;
      wr_data[0]  = 32'hDEADBEEF;
      wr_strb[0]  = 4'hF;
      advance();
      idle(0);
      rd_valid[0] = 1'b1;
      rd_addr[0]  = 32'h10;
      @(negedge clk);
      n_chk++;
      if (rd_ready[0] !== 1'b1) $display("FAIL wr_rd_accept got=%b exp=1", rd_ready[0]);
      else n_pass++;
      advance();
      rd_valid[0] = 1'b0;
      for (int k = 1; k <= 4; k++) begin
         @(negedge clk);
         n_chk++;
         if (rd_ready[0] !== 1'b1) $display("FAIL wr_rd_rdy k=%0d got=%b exp=1", k, rd_ready[0]);
         else n_pass++;
         n_chk++;
         if (rd_data_valid[0] !== (k == 2)) $display("FAIL wr_rd_vld k=%0d got=%b exp=%b", k, rd_data_valid[0], k == 2);
         else n_pass++;
         if (k == 2) begin
            n_chk++;
            if (rd_data[0] !== 32'hDEADBEEF) $display("FAIL wr_rd_dat got=%h exp=deadbeef", rd_data[0]);
            else n_pass++;
         end
         advance();
      end
   endtask

   task automatic test_strobes();
      logic got;
      select(0);
      wr_valid[0] = 1'b1;
      wr_addr[0]  = 32'h8;
      wr_data[0]  = 32'h11223344;
      wr_strb[0]  = 4'hF;
      advance();
      wr_data[0]  = 32'hAABBCCDD;
      wr_strb[0]  = 4'b0101;
      advance();
      idle(0);
      rd_valid[0] = 1'b1;
      rd_addr[0]  = 32'h8;
      advance();
      rd_valid[0] = 1'b0;
      got = 1'b0;
      for (int k = 0; k < 8 && !got; k++) begin
         @(negedge clk);
         if (rd_data_valid[0]) begin
            got = 1'b1;
            n_chk++;
            if (rd_data[0] !== 32'h11BB33DD) $display("FAIL strobe_dat got=%h exp=11bb33dd", rd_data[0]);
            else n_pass++;
         end
         advance();
      end
      n_chk++;
      if (!got) $display("FAIL strobe_timeout got=no response exp=response");
      else n_pass++;
   endtask

   task automatic test_collision();
      logic [31:0] rsp [2];
      int          n;
      select(0);
      wr_valid[0] = 1'b1;
      wr_addr[0]  = 32'h20;
      wr_data[0]  = 32'h1;
      wr_strb[0]  = 4'hF;
      advance();
      wr_data[0]  = 32'h2;
      rd_valid[0] = 1'b1;
      rd_addr[0]  = 32'h20;
      advance();
      wr_valid[0] = 1'b0;
      advance();
      rd_valid[0] = 1'b0;
      n = 0;
      for (int k = 0; k < 10 && n < 2; k++) begin
         @(negedge clk);
         if (rd_data_valid[0]) begin
            rsp[n] = rd_data[0];
            n++;
         end
         advance();
      end
      n_chk++;
      if (n != 2) $display("FAIL collide_count got=%0d exp=2", n);
      else n_pass++;
      if (n == 2) begin
         n_chk++;
         if (rsp[0] !== 32'h1) $display("FAIL collide_old got=%h exp=00000001", rsp[0]);
         else n_pass++;
         n_chk++;
         if (rsp[1] !== 32'h2) $display("FAIL collide_new got=%h exp=00000002", rsp[1]);
         else n_pass++;
      end
   endtask

   task automatic test_backpressure();
      int          i;
      int          nrsp;
      logic        prev_stall;
      logic [31:0] prev_dat;
      select(1);
      rd_data_ready[1] = 1'b0;
      i          = 0;
      nrsp       = 0;
      prev_stall = 1'b0;
      prev_dat   = '0;
      for (int k = 0; k < 30 && nrsp < 5; k++) begin
         rd_addr[1]  = i * 4;
         rd_valid[1] = (i < 5);
         if (k == 8) rd_data_ready[1] = 1'b1;
         @(negedge clk);
         n_chk++;
         if (rd_ready[1] !== exp_rdy()) $display("FAIL bp_rdy k=%0d got=%b exp=%b", k, rd_ready[1], exp_rdy());
         else n_pass++;
         n_chk++;
         if (rd_data_valid[1] !== exp_vld()) $display("FAIL bp_vld k=%0d got=%b exp=%b", k, rd_data_valid[1], exp_vld());
         else n_pass++;
         if (exp_vld()) begin
            n_chk++;
            if (rd_data[1] !== q[0].dat) $display("FAIL bp_dat k=%0d got=%h exp=%h", k, rd_data[1], q[0].dat);
            else n_pass++;
         end
         if (prev_stall) begin
            n_chk++;
            if (rd_data[1] !== prev_dat) $display("FAIL bp_stable k=%0d got=%h exp=%h", k, rd_data[1], prev_dat);
            else n_pass++;
         end
         prev_stall = rd_data_valid[1] && !rd_data_ready[1];
         prev_dat   = rd_data[1];
         if (rd_valid[1] && rd_ready[1]) i++;
         if (rd_data_valid[1] && rd_data_ready[1]) nrsp++;
         advance();
      end
      idle(1);
      n_chk++;
      if (i != 5) $display("FAIL bp_accepts got=%0d exp=5", i);
      else n_pass++;
      n_chk++;
      if (nrsp != 5) $display("FAIL bp_responses got=%0d exp=5", nrsp);
      else n_pass++;
   endtask

   task automatic test_passthrough();
      select(2);
      wr_valid[2] = 1'b1;
      wr_addr[2]  = 32'h4;
      wr_data[2]  = 32'h55;
      wr_strb[2]  = 4'hF;
      advance();
      wr_valid[2]      = 1'b0;
      rd_addr[2]       = 32'h44;
      rd_valid[2]      = 1'b1;
      rd_data_ready[2] = 1'b1;
      #1;
      n_chk++;
      if (rd_data[2] !== 32'h55) $display("FAIL pass_alias_dat got=%h exp=00000055", rd_data[2]);
      else n_pass++;
      n_chk++;
      if (rd_data_valid[2] !== 1'b1) $display("FAIL pass_vld_hi got=%b exp=1", rd_data_valid[2]);
      else n_pass++;
      n_chk++;
      if (rd_ready[2] !== 1'b1) $display("FAIL pass_rdy_hi got=%b exp=1", rd_ready[2]);
      else n_pass++;
      rd_data_ready[2] = 1'b0;
      #1;
      n_chk++;
      if (rd_ready[2] !== 1'b0) $display("FAIL pass_rdy_lo got=%b exp=0", rd_ready[2]);
      else n_pass++;
      rd_valid[2] = 1'b0;
      #1;
      n_chk++;
      if (rd_data_valid[2] !== 1'b0) $display("FAIL pass_vld_lo got=%b exp=0", rd_data_valid[2]);
      else n_pass++;
      for (int k = 0; k < 16; k++) begin
         @(negedge clk);
         rd_addr[2]       = $urandom;
         rd_valid[2]      = 1'($urandom_range(0, 1));
         rd_data_ready[2] = 1'($urandom_range(0, 1));
         #1;
         n_chk++;
         if (rd_data[2] !== mdl[2][word_of(rd_addr[2])])
            $display("FAIL pass_rand_dat addr=%h got=%h exp=%h", rd_addr[2], rd_data[2], mdl[2][word_of(rd_addr[2])]);
         else n_pass++;
         n_chk++;
         if (rd_data_valid[2] !== exp_vld() || rd_ready[2] !== exp_rdy())
            $display("FAIL pass_rand_hs got=%b/%b exp=%b/%b", rd_data_valid[2], rd_ready[2], exp_vld(), exp_rdy());
         else n_pass++;
      end
      idle(2);
      advance();
   endtask

   task automatic test_reset_midflight();
      int   acc_cyc;
      logic got;
      select(3);
      wr_valid[3] = 1'b1;
      wr_addr[3]  = 32'h14;
      wr_data[3]  = 32'hC0FFEE01;
      wr_strb[3]  = 4'hF;
      advance();
      idle(3);
      for (int k = 0; k < 11; k++) begin
         rd_valid[3] = (k < 2);
         rd_addr[3]  = 32'h30 + 32'(k * 4);
         rst[3]      = (k == 2);
         @(negedge clk);
         n_chk++;
         if (rd_data_valid[3] !== 1'b0) $display("FAIL rstmid_vld k=%0d got=%b exp=0", k, rd_data_valid[3]);
         else n_pass++;
         if (k > 2) begin
            n_chk++;
            if (rd_ready[3] !== 1'b1) $display("FAIL rstmid_rdy k=%0d got=%b exp=1", k, rd_ready[3]);
            else n_pass++;
         end
         advance();
      end
      rd_valid[3] = 1'b1;
      rd_addr[3]  = 32'h14;
      acc_cyc     = cyc;
      advance();
      rd_valid[3] = 1'b0;
      got = 1'b0;
      for (int k = 0; k < 10 && !got; k++) begin
         @(negedge clk);
         if (rd_data_valid[3]) begin
            got = 1'b1;
            n_chk++;
            if (rd_data[3] !== 32'hC0FFEE01 || cyc - acc_cyc != 3)
               $display("FAIL rstmid_read got=%h@+%0d exp=c0ffee01@+3", rd_data[3], cyc - acc_cyc);
            else n_pass++;
         end
         advance();
      end
      n_chk++;
      if (!got) $display("FAIL rstmid_timeout got=no response exp=response");
      else n_pass++;
   endtask

   task automatic test_random(input int g);
      int pct;
      select(g);
      for (int k = 0; k < 320; k++) begin
         pct = (k < 160) ? 85 : 30;
         if (k >= 300) begin
            idle(g);
         end else begin
            rd_addr[g]       = $urandom & 32'hFFFF_F03F;
            rd_valid[g]      = ($urandom_range(0, 3) != 0);
            rd_data_ready[g] = ($urandom_range(0, 99) < pct);
            wr_valid[g]      = ($urandom_range(0, 2) == 0);
            wr_addr[g]       = $urandom & 32'hFFFF_F03F;
            wr_data[g]       = $urandom;
            wr_strb[g]       = 4'($urandom);
         end
         @(negedge clk);
         n_chk++;
         if (rd_ready[g] !== exp_rdy()) $display("FAIL rand_rdy inst=%0d k=%0d got=%b exp=%b", g, k, rd_ready[g], exp_rdy());
         else n_pass++;
         n_chk++;
         if (rd_data_valid[g] !== exp_vld()) $display("FAIL rand_vld inst=%0d k=%0d got=%b exp=%b", g, k, rd_data_valid[g], exp_vld());
         else n_pass++;
         if (exp_vld()) begin
            n_chk++;
            if (rd_data[g] !== q[0].dat) $display("FAIL rand_dat inst=%0d k=%0d got=%h exp=%h", g, k, rd_data[g], q[0].dat);
            else n_pass++;
         end
         advance();
      end
   endtask

   initial begin
      cyc    = 0;
      n_chk  = 0;
      n_pass = 0;
      cur    = 0;
      lat    = 0;
      test_reset();
      init_mem(0);
      test_write_read();
      test_strobes();
      test_collision();
      init_mem(1);
      test_backpressure();
      init_mem(2);
      test_passthrough();
      init_mem(3);
      test_reset_midflight();
      test_random(0);
      test_random(1);
      test_random(3);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
